// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: default widths and FSM state encodings.
package uart_tx_feeder_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_LAUNCH    = 2'b01,
      S_WAIT_ACK  = 2'b10,
      S_WAIT_DONE = 2'b11
   } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead head, registered full/empty/level and an overflow pulse.
module uart_sync_fifo
   import uart_tx_feeder_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_overflow;

   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [CNT_WIDTH-1:0]  w_count_nxt;

   // Acceptance uses the registered flags: a full FIFO rejects writes even if it pops this cycle.
   assign w_wr_ok = wr_en && !r_full;
   assign w_rd_ok = rd_en && !r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_ok, w_rd_ok})
         2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
         2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == CNT_WIDTH'(FIFO_DEPTH));
         r_empty    <= (w_count_nxt == '0);
         r_overflow <= wr_en && r_full;
      end
   end

   assign rd_data  = r_mem[r_rd_ptr];
   assign full     = r_full;
   assign empty    = r_empty;
   assign level    = r_count;
   assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered host bytes to a UART transmitter one frame at a time, holding each byte for the whole frame.
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   input  logic                  tx_dv,
   output logic                  tx_start,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  busy
);

   feeder_state_e         r_state;
   feeder_state_e         w_state_nxt;
   logic                  r_tx_start;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_tx_data;

   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_empty;

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (w_pop),
      .rd_data  (w_head),
      .full     (full),
      .empty    (w_empty),
      .level    (level),
      .overflow (overflow)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && tx_dv) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH:    w_state_nxt = S_WAIT_ACK;
         S_WAIT_ACK:  if (!tx_dv) w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (tx_dv)  w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // tx_data only loads on the pop, so it stays frozen until the next launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_start <= (w_state_nxt == S_LAUNCH);
         r_busy     <= (w_state_nxt != S_IDLE);
         if (w_pop) begin
            r_tx_data <= w_head;
         end
      end
   end

   assign empty    = w_empty;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed-vector bench for uart_tx_feeder; tx_dv is driven as the transmitter would drive it.
module tb_uart_tx_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       overflow;
   logic       tx_dv;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_feeder dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .tx_dv    (tx_dv),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       dv;
      logic       e_start;
      int         e_lvl;
      logic       e_ovf;
      logic       e_busy;
      logic [7:0] e_data;
   } vec_t;

   vec_t vq[$];
   logic [7:0] exp_q[$];

   function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic dv,
                               input logic st, input int lvl, input logic o,
                               input logic b, input logic [7:0] ed);
      vec_t v;
      v.wr = wr; v.d = d; v.dv = dv; v.e_start = st; v.e_lvl = lvl;
      v.e_ovf = o; v.e_busy = b; v.e_data = ed;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic w, input logic [7:0] d, input logic v);
      @(negedge clk);
      wr_en = w; wr_data = d; tx_dv = v;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input int idx);
      chk("rst_tx_start", idx, 32'(tx_start), 32'd0);
      chk("rst_level",    idx, 32'(level),    32'd0);
      chk("rst_empty",    idx, 32'(empty),    32'd1);
      chk("rst_full",     idx, 32'(full),     32'd0);
      chk("rst_overflow", idx, 32'(overflow), 32'd0);
      chk("rst_busy",     idx, 32'(busy),     32'd0);
      chk("rst_tx_data",  idx, 32'(tx_data),  32'd0);
   endtask

   // Transmitter leaves idle after the launch and stays busy for a few cycles; data must not move.
   task automatic finish_frame(input logic [7:0] exp, input int idx);
      repeat (3) begin
         step(1'b0, 8'h00, 1'b0);
         chk("frame_tx_data",  idx, 32'(tx_data),  32'(exp));
         chk("frame_tx_start", idx, 32'(tx_start), 32'd0);
         chk("frame_busy",     idx, 32'(busy),     32'd1);
      end
   endtask

   initial begin
      int steps;
      int remaining;

      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_dv = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_vals(0);

      // Single byte, frame timing, writes during a frame, tx_dv low in idle.
      vq.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1,  1'b0, 1'b0, 8'h00));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 0,  1'b0, 1'b1, 8'hA5));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0,  1'b0, 1'b1, 8'hA5));
      vq.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 0,  1'b0, 1'b1, 8'hA5));
      vq.push_back(mk(1'b1, 8'h3C, 1'b0, 1'b0, 1,  1'b0, 1'b1, 8'hA5));
      vq.push_back(mk(1'b1, 8'h5A, 1'b0, 1'b0, 2,  1'b0, 1'b1, 8'hA5));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 2,  1'b0, 1'b0, 8'hA5));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1,  1'b0, 1'b1, 8'h3C));
      vq.push_back(mk(1'b1, 8'h77, 1'b1, 1'b0, 2,  1'b0, 1'b1, 8'h3C));
      vq.push_back(mk(1'b1, 8'h88, 1'b0, 1'b0, 3,  1'b0, 1'b1, 8'h3C));
      vq.push_back(mk(1'b1, 8'h99, 1'b0, 1'b0, 4,  1'b0, 1'b1, 8'h3C));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 4,  1'b0, 1'b0, 8'h3C));
      vq.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 4,  1'b0, 1'b0, 8'h3C));
      // Fill to full while the transmitter holds tx_dv low.
      for (int i = 0; i < 12; i++)
         vq.push_back(mk(1'b1, 8'(8'h01 + i), 1'b0, 1'b0, 5 + i, 1'b0, 1'b0, 8'h3C));
      vq.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 8'h3C));
      vq.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b0, 1'b0, 8'h3C));
      // Write while full in the same cycle as a pop: rejected, level drops to 15.
      vq.push_back(mk(1'b1, 8'hEE, 1'b1, 1'b1, 15, 1'b1, 1'b1, 8'h5A));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15, 1'b0, 1'b1, 8'h5A));
      vq.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0, 1'b1, 8'h5A));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15, 1'b0, 1'b0, 8'h5A));
      vq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 14, 1'b0, 1'b1, 8'h77));

      foreach (vq[k]) begin
         step(vq[k].wr, vq[k].d, vq[k].dv);
         chk("tx_start", k, 32'(tx_start), 32'(vq[k].e_start));
         chk("level",    k, 32'(level),    32'(vq[k].e_lvl));
         chk("full",     k, 32'(full),     32'(vq[k].e_lvl == 16));
         chk("empty",    k, 32'(empty),    32'(vq[k].e_lvl == 0));
         chk("overflow", k, 32'(overflow), 32'(vq[k].e_ovf));
         chk("busy",     k, 32'(busy),     32'(vq[k].e_busy));
         chk("tx_data",  k, 32'(tx_data),  32'(vq[k].e_data));
      end

      // Drain: remaining bytes in order, one launch each, one idle cycle between frames.
      exp_q.push_back(8'h88);
      exp_q.push_back(8'h99);
      for (int i = 0; i < 12; i++) exp_q.push_back(8'(8'h01 + i));
      finish_frame(8'h77, 100);
      remaining = exp_q.size();
      foreach (exp_q[k]) begin
         steps = 0;
         do begin
            step(1'b0, 8'h00, 1'b1);
            steps++;
         end while (!tx_start && steps < 6);
         chk("drain_gap",   k, 32'(steps),   32'd2);
         chk("drain_data",  k, 32'(tx_data), 32'(exp_q[k]));
         remaining--;
         chk("drain_level", k, 32'(level),   32'(remaining));
         finish_frame(exp_q[k], 200 + k);
      end
      step(1'b0, 8'h00, 1'b1);
      chk("drain_busy",  0, 32'(busy),  32'd0);
      chk("drain_empty", 0, 32'(empty), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      chk("drain_no_start", 0, 32'(tx_start), 32'd0);

      // Reset mid-frame with 5 bytes queued.
      step(1'b1, 8'hA1, 1'b1);
      step(1'b1, 8'hA2, 1'b1);
      chk("pre_rst_start", 0, 32'(tx_start), 32'd1);
      step(1'b1, 8'hA3, 1'b0);
      step(1'b1, 8'hA4, 1'b0);
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'hA6, 1'b0);
      chk("pre_rst_level", 0, 32'(level), 32'd5);
      @(negedge clk);
      wr_en = 1'b0; tx_dv = 1'b0; rst = 1'b1;
      #1;
      chk_reset_vals(1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("post_rst_start", i, 32'(tx_start), 32'd0);
         chk("post_rst_level", i, 32'(level),    32'd0);
         chk("post_rst_busy",  i, 32'(busy),     32'd0);
      end
      step(1'b1, 8'hB7, 1'b1);
      chk("post_rst_wr_level", 0, 32'(level),    32'd1);
      chk("post_rst_wr_start", 0, 32'(tx_start), 32'd0);
      step(1'b0, 8'h00, 1'b1);
      chk("post_rst_launch", 0, 32'(tx_start), 32'd1);
      chk("post_rst_data",   0, 32'(tx_data),  32'hB7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
